md_fetch_seq: RTL and testbench

MD_FETCH_SEQ -- requirements
Module: md_fetch_seq

---
 rtl/md_fetch_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_md_fetch_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_fetch_seq.sv
// md_fetch_seq: fetches one LCU of original pixels block by block (8x8, Z-order).
// Each block takes two 32-pixel reads. The reads are unpacked into a block buffer,
// then handed to a consumer through a bank valid/ack handshake.
// Optional macro MD_FETCH_PINGPONG_EN: when defined, two buffer banks alternate.
// When undefined, a single bank (bank 0) is used.
module md_fetch_seq #(
  parameter  int LCU_SIZE = 64,
  parameter  int PIX_W    = 8,
  localparam int NBLK     = (LCU_SIZE / 8) * (LCU_SIZE / 8),
  localparam int BLK_W    = $clog2(NBLK)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 lcu_done,
  output logic                 md_ren_o,
  output logic [3:0]           md_4x4_x_o,
  output logic [3:0]           md_4x4_y_o,
  input  logic [32*PIX_W-1:0]  md_data_i,
  output logic                 buf_we,
  output logic                 buf_bank,
  output logic [3:0]           buf_waddr,
  output logic [4*PIX_W-1:0]   buf_wdata,
  output logic                 blk_valid,
  output logic                 blk_bank,
  output logic [BLK_W-1:0]     blk_idx,
  input  logic                 blk_ack
);

`ifdef MD_FETCH_PINGPONG_EN
  localparam logic PP_EN = 1'b1;
`else
  localparam logic PP_EN = 1'b0;
`endif

  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NBLK - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BANK = 3'd1,
    READ      = 3'd2,
    CAPT      = 3'd3,
    WRITE     = 3'd4,
    COMMIT    = 3'd5
  } state_t;

  state_t                      state_r;
  logic [BLK_W-1:0]            blk_r;
  logic                        half_r;
  logic [2:0]                  j_r;
  logic                        drain_r;
  logic [1:0]                  full_r;
  logic                        wr_bank_r;
  logic                        rd_bank_r;
  logic [1:0][BLK_W-1:0]       idx_r;
  logic [32*PIX_W-1:0]         data_r;

  logic                        ack_s;
  logic                        commit_s;
  logic [1:0]                  full_nx_s;
  logic                        rd_bank_nx_s;
  logic [1:0][BLK_W-1:0]       idx_nx_s;
  logic [BLK_W-1:0]            blk_nx_s;

  // 2*x8: even bits of the Z-order index, deinterleaved, in 4x4 units
  function automatic logic [3:0] pos_x(input logic [5:0] b);
    return {b[4], b[2], b[0], 1'b0};
  endfunction

  // 2*y8 + half: odd bits of the Z-order index, deinterleaved, in 4x4 units
  function automatic logic [3:0] pos_y(input logic [5:0] b, input logic h);
    return {b[5], b[3], b[1], h};
  endfunction

  // Select write word j (pixels 4j..4j+3) from a captured 32-pixel read
  function automatic logic [4*PIX_W-1:0] word_at(input logic [32*PIX_W-1:0] d,
                                                 input logic [2:0] j);
    logic [4*PIX_W-1:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w = (j == 3'(i)) ? d[i*4*PIX_W +: 4*PIX_W] : w;
    end
    return w;
  endfunction

  assign ack_s    = blk_ack & blk_valid;
  assign commit_s = (state_r == COMMIT);
  assign blk_nx_s = blk_r + 1'b1;

  // Next bank bookkeeping: ack frees the read bank, commit fills the write bank
  always_comb begin
    full_nx_s    = full_r;
    rd_bank_nx_s = rd_bank_r;
    idx_nx_s     = idx_r;
    if (ack_s) begin
      full_nx_s[rd_bank_r] = 1'b0;
      rd_bank_nx_s         = rd_bank_r ^ PP_EN;
    end else begin
      rd_bank_nx_s = rd_bank_r;
    end
    if (commit_s) begin
      full_nx_s[wr_bank_r] = 1'b1;
      idx_nx_s[wr_bank_r]  = blk_r;
    end else begin
      idx_nx_s = idx_nx_s;
    end
  end

  // Fetch sequencer, bank state and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      blk_r      <= '0;
      half_r     <= 1'b0;
      j_r        <= 3'd0;
      drain_r    <= 1'b0;
      full_r     <= 2'b00;
      wr_bank_r  <= 1'b0;
      rd_bank_r  <= 1'b0;
      idx_r      <= '0;
      data_r     <= '0;
      md_ren_o   <= 1'b0;
      md_4x4_x_o <= 4'd0;
      md_4x4_y_o <= 4'd0;
      buf_we     <= 1'b0;
      buf_bank   <= 1'b0;
      buf_waddr  <= 4'd0;
      buf_wdata  <= '0;
      blk_valid  <= 1'b0;
      blk_bank   <= 1'b0;
      blk_idx    <= '0;
      lcu_done   <= 1'b0;
    end else begin
      full_r    <= full_nx_s;
      rd_bank_r <= rd_bank_nx_s;
      idx_r     <= idx_nx_s;
      blk_valid <= full_nx_s[rd_bank_nx_s];
      blk_bank  <= rd_bank_nx_s;
      blk_idx   <= idx_nx_s[rd_bank_nx_s];
      lcu_done  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) state_r <= WAIT_BANK;
          else       state_r <= IDLE;
        end
        WAIT_BANK: begin
          if (drain_r) begin
            // last block committed: finish once the consumer has emptied both banks
            if (full_r == 2'b00) begin
              lcu_done <= 1'b1;
              drain_r  <= 1'b0;
              state_r  <= IDLE;
            end else begin
              state_r <= WAIT_BANK;
            end
          end else if (!full_r[wr_bank_r]) begin
            state_r    <= READ;
            md_ren_o   <= 1'b1;
            half_r     <= 1'b0;
            md_4x4_x_o <= pos_x(6'(blk_r));
            md_4x4_y_o <= pos_y(6'(blk_r), 1'b0);
          end else begin
            state_r <= WAIT_BANK;
          end
        end
        READ: begin
          md_ren_o <= 1'b0;
          state_r  <= CAPT;
        end
        CAPT: begin
          // read data is valid now; word 0 goes straight out, the rest is held
          data_r    <= md_data_i;
          buf_we    <= 1'b1;
          buf_bank  <= wr_bank_r;
          buf_waddr <= {half_r, 3'd0};
          buf_wdata <= md_data_i[0 +: 4*PIX_W];
          j_r       <= 3'd0;
          state_r   <= WRITE;
        end
        WRITE: begin
          if (j_r != 3'd7) begin
            j_r       <= j_r + 3'd1;
            buf_waddr <= {half_r, j_r + 3'd1};
            buf_wdata <= word_at(data_r, j_r + 3'd1);
          end else begin
            buf_we <= 1'b0;
            if (!half_r) begin
              half_r     <= 1'b1;
              md_ren_o   <= 1'b1;
              md_4x4_y_o <= pos_y(6'(blk_r), 1'b1);
              state_r    <= READ;
            end else begin
              half_r  <= 1'b0;
              state_r <= COMMIT;
            end
          end
        end
        COMMIT: begin
          wr_bank_r <= wr_bank_r ^ PP_EN;
          blk_r     <= blk_nx_s;
          if (blk_r == LAST_BLK) begin
            drain_r <= 1'b1;
            state_r <= WAIT_BANK;
          end else if (PP_EN && !full_r[~wr_bank_r]) begin
            // other bank already free: start the next block without a wait cycle
            state_r    <= READ;
            md_ren_o   <= 1'b1;
            half_r     <= 1'b0;
            md_4x4_x_o <= pos_x(6'(blk_nx_s));
            md_4x4_y_o <= pos_y(6'(blk_nx_s), 1'b0);
          end else begin
            state_r <= WAIT_BANK;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_fetch_seq.sv
// Self-checking bench for md_fetch_seq (LCU_SIZE=64, PIX_W=8).
// Expectations for reads, buffer writes and delivered blocks are queued when
// stimulus is driven and compared when the DUT produces the matching output.
module tb_md_fetch_seq;
  localparam int LCU_SIZE = 64;
  localparam int PIX_W    = 8;
  localparam int NBLK     = (LCU_SIZE / 8) * (LCU_SIZE / 8);
  localparam int BLK_W    = $clog2(NBLK);
`ifdef MD_FETCH_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 lcu_done;
  logic                 md_ren_o;
  logic [3:0]           md_4x4_x_o;
  logic [3:0]           md_4x4_y_o;
  logic [32*PIX_W-1:0]  md_data_i;
  logic                 buf_we;
  logic                 buf_bank;
  logic [3:0]           buf_waddr;
  logic [4*PIX_W-1:0]   buf_wdata;
  logic                 blk_valid;
  logic                 blk_bank;
  logic [BLK_W-1:0]     blk_idx;
  logic                 blk_ack;

  md_fetch_seq #(.LCU_SIZE(LCU_SIZE), .PIX_W(PIX_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .lcu_done(lcu_done),
    .md_ren_o(md_ren_o), .md_4x4_x_o(md_4x4_x_o), .md_4x4_y_o(md_4x4_y_o),
    .md_data_i(md_data_i), .buf_we(buf_we), .buf_bank(buf_bank),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .blk_valid(blk_valid),
    .blk_bank(blk_bank), .blk_idx(blk_idx), .blk_ack(blk_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] x; logic [3:0] y; } rd_t;
  typedef struct { logic [3:0] addr; logic [31:0] data; logic bank; int blk; } wr_t;
  typedef struct { int idx; logic bank; } bk_t;

  rd_t exp_rd[$];
  wr_t exp_wr[$];
  bk_t exp_bk[$];

  int checks = 0, errors = 0;
  int cyc = 0, rd_seq = 0, done_cnt = 0, ack_cycle = 0, prev_h0 = 0;
  int wait_cnt = 0, ack_dly = 1, tmode = 0;
  bit auto_ack = 1'b0, ren_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int coord(input int b, input int odd);
    int v = 0;
    for (int i = 0; i < 3; i++) v = v | (((b >> (2*i + odd)) & 1) << i);
    return v;
  endfunction

  function automatic int pix(input int n, input int k);
    return (n < 2) ? k : ((k * 3 + n) & 255);
  endfunction

  function automatic logic [31:0] word(input int n, input int j);
    logic [31:0] w;
    for (int p = 0; p < 4; p++) w[8*p +: 8] = 8'(pix(n, 4*j + p));
    return w;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({lcu_done, md_ren_o, md_4x4_x_o, md_4x4_y_o, buf_we, buf_bank,
                buf_waddr, buf_wdata, blk_valid, blk_bank, blk_idx});
  endfunction

  task automatic ack_now();
    bk_t b;
    if (exp_bk.size() == 0) chk("ack_extra", 64'd1, 64'd0);
    else begin
      b = exp_bk.pop_front();
      chk("blk_idx", 64'(blk_idx), 64'(b.idx));
      chk("blk_bank", 64'(blk_bank), 64'(b.bank));
    end
    blk_ack   = 1'b1;
    ack_cycle = cyc;
  endtask

  // One cycle: wait for the falling edge, then monitor, drive data and consume
  task automatic tick();
    rd_t r;
    wr_t w;
    @(negedge clk);
    cyc++;
    if (md_ren_o) begin
      chk("ren_we_excl", 64'(buf_we), 64'd0);
      if (exp_rd.size() == 0) chk("rd_extra", 64'd1, 64'd0);
      else begin
        r = exp_rd.pop_front();
        chk("rd_x", 64'(md_4x4_x_o), 64'(r.x));
        chk("rd_y", 64'(md_4x4_y_o), 64'(r.y));
      end
      if (rd_seq % 2 == 0) begin
        if (rd_seq > 0 && tmode == 1) chk("blk_period", 64'(cyc - prev_h0), 64'd21);
        if (rd_seq > 0 && tmode == 2) chk("ack_to_ren", 64'(cyc - ack_cycle), 64'd2);
        prev_h0 = cyc;
      end
    end
    if (ren_prev) begin
      for (int k = 0; k < 32; k++) md_data_i[k*PIX_W +: PIX_W] = 8'(pix(rd_seq, k));
      for (int j = 0; j < 8; j++) begin
        w.addr = 4'((rd_seq % 2) * 8 + j);
        w.data = word(rd_seq, j);
        w.bank = PP ? 1'((rd_seq / 2) % 2) : 1'b0;
        w.blk  = rd_seq / 2;
        exp_wr.push_back(w);
      end
      rd_seq++;
    end else begin
      md_data_i = '1;
    end
    ren_prev = md_ren_o;
    if (buf_we) begin
      if (exp_wr.size() == 0) chk("wr_extra", 64'd1, 64'd0);
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", 64'(buf_waddr), 64'(w.addr));
        chk("wr_data", 64'(buf_wdata), 64'(w.data));
        chk("wr_bank", 64'(buf_bank), 64'(w.bank));
        if (w.blk == 0 && (w.addr == 4'd3 || w.addr == 4'd11))
          chk("wr_word3", 64'(buf_wdata), 64'h0F0E0D0C);
      end
    end
    if (lcu_done) done_cnt++;
    if (blk_ack) blk_ack = 1'b0;
    else if (auto_ack && blk_valid) begin
      if (wait_cnt >= ack_dly) begin
        ack_now();
        wait_cnt = 0;
      end else wait_cnt++;
    end
  endtask

  task automatic flush();
    exp_rd.delete();
    exp_wr.delete();
    exp_bk.delete();
    rd_seq = 0; ren_prev = 1'b0; wait_cnt = 0; prev_h0 = 0; done_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; blk_ack = 1'b0;
    tick();
    tick();
    flush();
    rst = 1'b0;
  endtask

  task automatic start_lcu();
    rd_t r;
    bk_t b;
    for (int i = 0; i < NBLK; i++) begin
      for (int h = 0; h < 2; h++) begin
        r.x = 4'(2 * coord(i, 0));
        r.y = 4'(2 * coord(i, 1) + h);
        exp_rd.push_back(r);
      end
      b.idx  = i;
      b.bank = PP ? 1'(i % 2) : 1'b0;
      exp_bk.push_back(b);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int seen15;
    rst = 1'b1; start = 1'b0; blk_ack = 1'b0; md_data_i = '0;
    tick();
    tick();
    chk("reset_outs", all_outs(), 64'd0);
    flush();
    rst = 1'b0;

    // Stall: no acks, banks fill, then a single ack releases the next read
    auto_ack = 1'b0; tmode = 0;
    start_lcu();
    repeat (150) tick();
    chk("stall_reads", 64'(rd_seq), PP ? 64'd4 : 64'd2);
    chk("stall_ren_low", 64'(md_ren_o), 64'd0);
    chk("stall_valid", 64'(blk_valid), 64'd1);
    tmode = 2;
    ack_now();
    n = 0;
    do begin
      tick();
      n++;
    end while (!md_ren_o && n < 10);
    chk("stall_resume", 64'(md_ren_o), 64'd1);

    // Reset on the cycle after a read request
    tick();
    rst = 1'b1;
    tick();
    chk("midop_reset", all_outs(), 64'd0);
    flush();
    rst = 1'b0;
    tmode = 0;

    // Full LCU with prompt acks; a stray start mid-LCU must be ignored
    auto_ack = 1'b1; ack_dly = 1; tmode = PP ? 1 : 2;
    start_lcu();
    n = 0;
    while (done_cnt == 0 && n < 6000) begin
      tick();
      n++;
      start = (n == 500) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    repeat (30) tick();
    chk("lcu_done_cnt", 64'(done_cnt), 64'd1);
    chk("reads_total", 64'(rd_seq), 64'(2 * NBLK));
    chk("rd_left", 64'(exp_rd.size()), 64'd0);
    chk("blk_left", 64'(exp_bk.size()), 64'd0);
    chk("wr_left", 64'(exp_wr.size()), 64'd0);
    chk("idle_valid", 64'(blk_valid), 64'd0);

    // Ack landing in a commit cycle
    auto_ack = 1'b0; tmode = 0;
    do_reset();
    start_lcu();
    seen15 = 0; n = 0;
    while (seen15 < (PP ? 2 : 1) && n < 200) begin
      tick();
      n++;
      if (buf_we && buf_waddr == 4'd15) seen15++;
    end
    tick();
    chk("pre_commit_valid", 64'(blk_valid), 64'(PP));
    if (blk_valid) ack_now();
    else begin
      blk_ack = 1'b1;
      ack_cycle = cyc;
    end
    tick();
    chk("sim_valid", 64'(blk_valid), 64'd1);
    ack_now();
    tick();
    chk("sim_one_full", 64'(blk_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
